// File: rtl/lcd_pkg.sv
// Shared constants, state types and command classification for the HD44780 writer.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE0    = 8'h80;
    localparam logic [7:0] LCD_LINE1    = 8'hC0;

    typedef enum logic [1:0] {
        ST_WAIT_INIT,
        ST_CFG_ISSUE,
        ST_BUS,
        ST_READY
    } writer_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD,
        PH_EXEC
    } bus_phase_t;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data inside {8'h01, 8'h02, 8'h03});
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: SETUP -> STROBE -> HOLD -> EXEC, timed by a single down-counter.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int CLEAR_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       lcd_en
);

    localparam int CNT_W = $clog2(CLEAR_CYC + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    bus_phase_t phase_q, phase_d;
    cnt_t       cnt_q, cnt_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       en_q, en_d;

    // A phase lasts (reload + 1) cycles; done fires on the last EXEC cycle so a
    // follow-on start can be taken on the same edge.
    assign done = (phase_q == PH_EXEC) && (cnt_q == '0);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        en_d    = en_q;
        if (phase_q != PH_IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_STROBE;
                    en_d    = 1'b1;
                    cnt_d   = cnt_t'(EN_CYC - 1);
                end
                PH_STROBE: begin
                    phase_d = PH_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = cnt_t'(HOLD_CYC - 1);
                end
                PH_HOLD: begin
                    phase_d = PH_EXEC;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? cnt_t'(CLEAR_CYC - 1)
                                                        : cnt_t'(EXEC_CYC - 1);
                end
                PH_EXEC: phase_d = PH_IDLE;
                default: phase_d = PH_IDLE;
            endcase
        end
        if (start) begin
            phase_d = PH_SETUP;
            rs_d    = rs;
            data_d  = data;
            cnt_d   = cnt_t'(SETUP_CYC);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;
    assign lcd_en   = en_q;

endmodule

// File: rtl/lcd_cmd_writer.sv
// HD44780 command writer: config ROM replay, host byte handshake, optional cursor
// tracking with automatic line wrap under LCD_WRITER_CURSOR_TRACK_EN.
module lcd_cmd_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int CLEAR_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       cfg_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    // Handshake: a byte transfers on the clock edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in READY, and cmd_valid may be held with stable data.
    writer_state_t state_q, state_d;
    logic [1:0]    cfg_idx_q, cfg_idx_d;
    logic          cfg_done_q, cfg_done_d;
    logic          ready_q, ready_d;
    logic          accept, start, start_rs, bus_done;
    logic [7:0]    start_data;
    logic          insert_now, resume;
    logic [7:0]    insert_cmd, held_data;

    assign accept = cmd_valid && ready_q;

    function automatic logic [7:0] cfg_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cfg_idx_d  = cfg_idx_q;
        cfg_done_d = cfg_done_q;
        ready_d    = ready_q;
        start      = 1'b0;
        start_rs   = 1'b0;
        start_data = 8'h00;
        case (state_q)
            ST_WAIT_INIT: if (init_done) state_d = ST_CFG_ISSUE;
            ST_CFG_ISSUE: begin
                start      = 1'b1;
                start_data = cfg_rom(cfg_idx_q);
                state_d    = ST_BUS;
            end
            ST_BUS: if (bus_done) begin
                if (resume) begin
                    start      = 1'b1;
                    start_rs   = 1'b1;
                    start_data = held_data;
                end else if (!cfg_done_q && cfg_idx_q != 2'd3) begin
                    cfg_idx_d = cfg_idx_q + 2'd1;
                    state_d   = ST_CFG_ISSUE;
                end else begin
                    cfg_done_d = 1'b1;
                    ready_d    = 1'b1;
                    state_d    = ST_READY;
                end
            end
            ST_READY: if (accept) begin
                ready_d    = 1'b0;
                state_d    = ST_BUS;
                start      = 1'b1;
                start_rs   = insert_now ? 1'b0 : cmd_rs;
                start_data = insert_now ? insert_cmd : cmd_data;
            end
            default: state_d = ST_WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_WAIT_INIT;
            cfg_idx_q  <= 2'd0;
            cfg_done_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_idx_q  <= cfg_idx_d;
            cfg_done_q <= cfg_done_d;
            ready_q    <= ready_d;
        end
    end

`ifdef LCD_WRITER_CURSOR_TRACK_EN
    logic [4:0] col_q, col_d;
    logic       line_q, line_d;
    logic       pend_q, pend_d;
    logic [7:0] pend_data_q, pend_data_d;

    assign insert_now = cmd_rs && (col_q == 5'd16);
    assign insert_cmd = line_q ? LCD_LINE0 : LCD_LINE1;
    assign resume     = pend_q;
    assign held_data  = pend_data_q;

    // Cursor follows every byte as it is issued; the wrap command itself moves it.
    always_comb begin
        col_d       = col_q;
        line_d      = line_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        if (state_q == ST_READY && accept && insert_now) begin
            pend_d      = 1'b1;
            pend_data_d = cmd_data;
        end
        if (state_q == ST_BUS && bus_done && pend_q) pend_d = 1'b0;
        if (start) begin
            if (start_rs) begin
                if (col_q != 5'd16) col_d = col_q + 5'd1;
            end else if (is_long_cmd(1'b0, start_data)) begin
                col_d  = 5'd0;
                line_d = 1'b0;
            end else if (start_data[7]) begin
                line_d = start_data[6];
                col_d  = {1'b0, start_data[3:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= 5'd0;
            line_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
        end else begin
            col_q       <= col_d;
            line_q      <= line_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
        end
    end
`else
    assign insert_now = 1'b0;
    assign insert_cmd = 8'h00;
    assign resume     = 1'b0;
    assign held_data  = 8'h00;
`endif

    lcd_bus_cycle #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .EXEC_CYC  (EXEC_CYC),
        .CLEAR_CYC (CLEAR_CYC)
    ) u_bus (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rs       (start_rs),
        .data     (start_data),
        .done     (bus_done),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .lcd_en   (lcd_en)
    );

    assign cmd_ready = ready_q;
    assign cfg_done  = cfg_done_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_writer.sv
// Bench for lcd_cmd_writer: bus monitor with scoreboard queue plus phase timing checks.
module tb_lcd_cmd_writer;

    localparam int S = 2;
    localparam int E = 12;
    localparam int H = 2;
    localparam int X = 50;
    localparam int C = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_done = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, cfg_done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd_cmd_writer #(
        .SETUP_CYC (S),
        .EN_CYC    (E),
        .HOLD_CYC  (H),
        .EXEC_CYC  (X),
        .CLEAR_CYC (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .cfg_done  (cfg_done),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    int         edge_cnt = 0;
    int         acc_edge = 0;
    int         acc_seq = 0;
    int         init_edge = 0;
    int         rise_cnt = 0;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_wait(input logic [8:0] b);
        return (!b[8] && b[7:0] >= 8'h01 && b[7:0] <= 8'h03) ? C : X;
    endfunction

    // Bus monitor: every lcd_en pulse pops one expected {rs,data}.
    initial begin
        logic       prev_en = 1'b0;
        logic       prev_rdy = 1'b0;
        logic       first_rise = 1'b1;
        logic       have_fall = 1'b0;
        logic [8:0] prev_bus = 9'h000;
        logic [8:0] rise_bus = 9'h000;
        logic [8:0] exp_b;
        int         chg_edge = 0;
        int         last_rise = 0;
        int         fall_edge = 0;
        int         seen_acc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_en    = 1'b0;
                prev_rdy   = 1'b0;
                first_rise = 1'b1;
                have_fall  = 1'b0;
                seen_acc   = acc_seq;
            end else begin
                if ({lcd_rs, lcd_data} != prev_bus) chg_edge = edge_cnt;
                prev_bus = {lcd_rs, lcd_data};
                if (lcd_en && !prev_en) begin
                    rise_cnt++;
                    check_eq("ready_low_during_cycle", {31'd0, cmd_ready}, 32'd0);
                    check_eq("setup_stable", {31'd0, (edge_cnt - chg_edge) >= S + 1}, 32'd1);
                    check_eq("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check_eq("bus_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_b});
                    end
                    if (first_rise)
                        check_eq("init_to_en", edge_cnt - init_edge, S + 2);
                    else if (!cfg_done)
                        check_eq("cfg_gap", edge_cnt - last_rise, E + H + S + 2 + exp_wait(rise_bus));
                    if (acc_seq != seen_acc) begin
                        seen_acc = acc_seq;
                        check_eq("accept_to_en", edge_cnt - acc_edge, S + 1);
                    end
                    first_rise = 1'b0;
                    last_rise  = edge_cnt;
                    rise_bus   = {lcd_rs, lcd_data};
                end
                if (!lcd_en && prev_en) begin
                    check_eq("en_width", edge_cnt - last_rise, E);
                    check_eq("bus_held", {23'd0, lcd_rs, lcd_data}, {23'd0, rise_bus});
                    fall_edge = edge_cnt;
                    have_fall = 1'b1;
                end
                if (cmd_ready && !prev_rdy && have_fall)
                    check_eq("fall_to_ready", edge_cnt - fall_edge, H + exp_wait(rise_bus));
                prev_en  = lcd_en;
                prev_rdy = cmd_ready;
            end
        end
    end

    task automatic send_byte(input logic rs, input logic [7:0] d, input bit keep);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = d;
        exp_q.push_back({rs, d});
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check_eq("accept_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_edge = edge_cnt;
            acc_seq++;
            if (!keep) cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_cfg();
        int n = 0;
        while (!cfg_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("cfg_done", {31'd0, cfg_done}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic quiet_window(input int cycles, input string tag);
        int   r0 = rise_cnt;
        logic any_rdy = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            any_rdy |= cmd_ready;
        end
        check_eq({tag, "_no_en"}, rise_cnt - r0, 0);
        check_eq({tag, "_no_ready"}, {31'd0, any_rdy}, 32'd0);
    endtask

    task automatic run_config();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        init_edge = edge_cnt + 1;
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
        wait_cfg();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_en", {31'd0, lcd_en}, 32'd0);
        check_eq("rst_data", {24'd0, lcd_data}, 32'd0);
        check_eq("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check_eq("rst_rw", {31'd0, lcd_rw}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_cfg_done", {31'd0, cfg_done}, 32'd0);

        quiet_window(1000, "wait_init");
        run_config();

        for (int i = 0; i < 16; i++) send_byte(1'b1, 8'(8'h61 + i), 1'b0);
`ifdef LCD_WRITER_CURSOR_TRACK_EN
        exp_q.push_back({1'b0, 8'hC0});
`endif
        send_byte(1'b1, 8'h71, 1'b0);
        send_byte(1'b0, 8'h80, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(1'b1, 8'(8'h30 + i), 1'b0);

        send_byte(1'b0, 8'h02, 1'b0);
        send_byte(1'b0, 8'h0C, 1'b0);
        send_byte(1'b1, 8'h41, 1'b0);
        send_byte(1'b1, 8'h42, 1'b1);
        send_byte(1'b1, 8'h43, 1'b1);
        send_byte(1'b1, 8'h44, 1'b0);
        wait_idle();
        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("cfg_done_sticky", {31'd0, cfg_done}, 32'd1);

        send_byte(1'b1, 8'h55, 1'b0);
        n = 0;
        while (!lcd_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("en_before_reset", {31'd0, lcd_en}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("async_en", {31'd0, lcd_en}, 32'd0);
        check_eq("async_data", {24'd0, lcd_data}, 32'd0);
        check_eq("async_rs", {31'd0, lcd_rs}, 32'd0);
        check_eq("async_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("async_cfg_done", {31'd0, cfg_done}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        quiet_window(200, "post_reset");
        run_config();
        send_byte(1'b1, 8'h5A, 1'b0);
        wait_idle();
        check_eq("queue_drained_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
